// File: rtl/sub_table_pkg.sv
// Shared definitions for the substitution-table stream codec.
// Holds the table geometry, the key positions that label each table row and
// column, the symbol alphabet, the key-manager state type and small
// character-classification helpers.
package sub_table_pkg;

  localparam int ROWS    = 6;
  localparam int COLS    = 6;
  localparam int KEY_LEN = ROWS + COLS;
  localparam int NUM_SYM = ROWS * COLS;

  // Key byte that labels each row / column of the 6x6 table.
  localparam logic [3:0] ROW_IDX [ROWS] = '{4'd0, 4'd11, 4'd9, 4'd3, 4'd5, 4'd6};
  localparam logic [3:0] COL_IDX [COLS] = '{4'd10, 4'd8, 4'd1, 4'd2, 4'd4, 4'd7};

  // Symbol k of the table is the k-th character here (leftmost = symbol 0).
  localparam logic [8*NUM_SYM-1:0] ALPHABET = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";

  typedef enum logic [1:0] {
    NO_KEY  = 2'd0,
    CHECK   = 2'd1,
    READY   = 2'd2,
    KEY_ERR = 2'd3
  } key_state_e;

  function automatic logic is_alnum(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) ||
           (b >= 8'h41 && b <= 8'h5A) ||
           (b >= 8'h61 && b <= 8'h7A);
  endfunction

  function automatic logic [7:0] to_upper(input logic [7:0] b);
    return (b >= 8'h61 && b <= 8'h7A) ? (b - 8'h20) : b;
  endfunction

  function automatic logic [7:0] sym_char(input int k);
    return ALPHABET[8*(NUM_SYM-1-k) +: 8];
  endfunction

endpackage

// File: rtl/sub_table_fifo.sv
// Synchronous show-ahead FIFO with occupancy count.
// Ports: clk/rst (sync active-high); wr_en/wr_data/full for the write side
// (writes while full are dropped, even if a read happens in the same cycle);
// rd_en/rd_data/empty for the read side (rd_data is the current head);
// count = number of stored entries after each edge.
module sub_table_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       full,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] fifo_mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = fifo_mem[rd_ptr_q];
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/sub_table_stream_codec.sv
// Keyed 6x6 substitution-table codec on a valid/ready token stream.
// Ports: clk/rst (sync active-high); key_byte/byte_pos/key_byte_val write key
// bytes, key_commit starts the key check; key_ready/error_flag_key report the
// key state. in_valid/in_ready/in_data/in_mode/in_upper feed tokens into a
// FIFO (fifo_count = occupancy); out_valid/out_ready/out_data/out_err carry
// one registered result per token. Encrypt maps a letter/digit to the
// {row label, column label} byte pair; decrypt maps such a pair back.
module sub_table_stream_codec
  import sub_table_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int KEY_LEN    = sub_table_pkg::KEY_LEN
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [7:0]                      key_byte,
  input  logic [3:0]                      byte_pos,
  input  logic                            key_byte_val,
  input  logic                            key_commit,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [15:0]                     in_data,
  input  logic                            in_mode,
  input  logic                            in_upper,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [15:0]                     out_data,
  output logic                            out_err,
  output logic                            key_ready,
  output logic                            error_flag_key,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam logic [3:0] LAST_IDX = 4'(KEY_LEN - 1);

  // ---------------- key storage ----------------
  logic [7:0] key_q [KEY_LEN];
  logic [7:0] key_d [KEY_LEN];

  // Positions at or beyond KEY_LEN match no element and are thus ignored.
  for (genvar gi = 0; gi < KEY_LEN; gi++) begin : g_key
    assign key_d[gi] = (key_byte_val && byte_pos == 4'(gi)) ? key_byte : key_q[gi];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < KEY_LEN; i++) begin
      if (rst) key_q[i] <= 8'h00;
      else     key_q[i] <= key_d[i];
    end
  end

  // ---------------- key check FSM ----------------
  key_state_e          state_q, state_d;
  logic [3:0]          chk_idx_q, chk_idx_d;
  logic                chk_fail_q, chk_fail_d;
  logic [7:0]          chk_byte;
  logic [KEY_LEN-1:0]  dup_vec;
  logic                idx_bad;

  always_comb begin
    chk_byte = 8'h00;
    for (int i = 0; i < KEY_LEN; i++) begin
      if (chk_idx_q == 4'(i)) chk_byte = key_q[i];
    end
  end

  // Byte under test must differ from every earlier key byte.
  for (genvar gi = 0; gi < KEY_LEN; gi++) begin : g_dup
    assign dup_vec[gi] = (4'(gi) < chk_idx_q) && (key_q[gi] == chk_byte);
  end

  assign idx_bad = !is_alnum(chk_byte) || (|dup_vec);

  always_comb begin
    state_d    = state_q;
    chk_idx_d  = chk_idx_q;
    chk_fail_d = chk_fail_q;
    if (key_byte_val) begin
      state_d = NO_KEY;
    end else begin
      case (state_q)
        NO_KEY, KEY_ERR: begin
          if (key_commit) begin
            state_d    = CHECK;
            chk_idx_d  = 4'd0;
            chk_fail_d = 1'b0;
          end
        end
        CHECK: begin
          // Always walk all KEY_LEN bytes; the verdict comes on the last one.
          if (chk_idx_q == LAST_IDX) begin
            state_d = (chk_fail_q || idx_bad) ? KEY_ERR : READY;
          end else begin
            chk_idx_d  = chk_idx_q + 4'd1;
            chk_fail_d = chk_fail_q || idx_bad;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= NO_KEY;
      chk_idx_q  <= 4'd0;
      chk_fail_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      chk_idx_q  <= chk_idx_d;
      chk_fail_q <= chk_fail_d;
    end
  end

  assign key_ready      = (state_q == READY);
  assign error_flag_key = (state_q == KEY_ERR);

  // ---------------- token FIFO ----------------
  logic        fifo_full, fifo_empty, fifo_rd;
  logic [17:0] fifo_head;
  logic        head_mode, head_upper;
  logic [15:0] head_data;

  sub_table_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (18)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_valid),
    .wr_data ({in_mode, in_upper, in_data}),
    .full    (fifo_full),
    .rd_en   (fifo_rd),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign in_ready   = !fifo_full;
  assign head_mode  = fifo_head[17];
  assign head_upper = fifo_head[16];
  assign head_data  = fifo_head[15:0];

  // ---------------- table lookup ----------------
  logic        dec_hit, enc_hit;
  logic [7:0]  dec_char, dec_out, lo_up;
  logic [15:0] enc_pair;
  logic [15:0] res_data;
  logic        res_err;

  always_comb begin
    dec_hit  = 1'b0;
    dec_char = 8'h00;
    enc_hit  = 1'b0;
    enc_pair = 16'h0000;
    lo_up    = to_upper(head_data[7:0]);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if ({key_q[ROW_IDX[r]], key_q[COL_IDX[c]]} == head_data) begin
          dec_hit  = 1'b1;
          dec_char = sym_char(r*COLS + c);
        end
        if (lo_up == sym_char(r*COLS + c)) begin
          enc_hit  = 1'b1;
          enc_pair = {key_q[ROW_IDX[r]], key_q[COL_IDX[c]]};
        end
      end
    end
  end

  always_comb begin
    // Alphabet letters are upper case; fold to lower when requested.
    dec_out  = (!head_upper && dec_char >= 8'h41) ? (dec_char | 8'h20) : dec_char;
    res_data = 16'h0000;
    res_err  = 1'b0;
    if (head_mode) begin
      if (is_alnum(head_data[7:0]) && enc_hit) res_data = enc_pair;
      else                                     res_err  = 1'b1;
    end else begin
      if (is_alnum(head_data[15:8]) && is_alnum(head_data[7:0]) && dec_hit)
        res_data = {8'h00, dec_out};
      else
        res_err = 1'b1;
    end
  end

  // ---------------- output register ----------------
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_data_q, out_data_d;
  logic        out_err_q, out_err_d;

  assign fifo_rd = key_ready && !fifo_empty && (!out_valid_q || out_ready);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    if (fifo_rd) begin
      out_valid_d = 1'b1;
      out_data_d  = res_data;
      out_err_d   = res_err;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0000;
      out_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

endmodule

// File: doc/sub_table_stream_codec.md
SUB_TABLE_STREAM_CODEC -- requirements
Module: sub_table_stream_codec

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning input token FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter KEY_LEN, default 12, meaning key bytes, fixed to ROWS+COLS from the package.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-004 SHALL have key_byte  in  8  key character; byte_pos  in  4  key index; key_byte_val  in  1  write strobe; key_commit  in  1  start key check.
REQ-005 SHALL have in_valid  in  1; in_ready  out  1; in_data  in  16  token; in_mode  in  1  (0 decrypt, 1 encrypt); in_upper  in  1  plaintext case for decrypt.
REQ-006 SHALL have out_valid  out  1; out_ready  in  1; out_data  out  16  result; out_err  out  1  token error.
REQ-007 SHALL have key_ready  out  1; error_flag_key  out  1; fifo_count  out  $clog2(FIFO_DEPTH+1)  occupancy.

Function
REQ-008 Key FSM SHALL have the states NO_KEY, CHECK, READY and KEY_ERR; key_ready=1 only in READY; error_flag_key=1 only in KEY_ERR.
REQ-009 key_byte_val=1 SHALL write key[byte_pos] (byte_pos>=KEY_LEN ignored) and force NO_KEY next cycle from any state.
REQ-010 key_commit in NO_KEY or KEY_ERR SHALL enter CHECK; in CHECK/READY it SHALL be ignored; key_byte_val has priority over key_commit in the same cycle.
REQ-011 CHECK SHALL test one index i per cycle, i=0..KEY_LEN-1: key[i] alphanumeric and key[i] != key[j] for all j<i; exactly KEY_LEN cycles, then READY on pass, KEY_ERR on any failure.
REQ-012 in_ready SHALL equal (fifo not full); tokens accepted on in_valid&&in_ready together with in_mode/in_upper; no write-through when full even if popping.
REQ-013 The FIFO head SHALL be consumed only when key_ready=1 and (out_valid=0 or out_ready=1); the result is registered, giving 1-cycle minimum accept-to-out_valid latency.
REQ-014 out_data/out_err SHALL hold stable while out_valid&&!out_ready.
REQ-015 Decrypt: in_data[15:8]=row char, [7:0]=col char; match {S[ROW_IDX[r]],S[COL_IDX[c]]} gives symbol index r*COLS+c of alphabet A..Z,0..9; letters upper if in_upper else lower; out_data={8'h00,char}.
REQ-016 Encrypt: in_data[7:0] letter (either case) or digit; out_data={S[ROW_IDX[r]],S[COL_IDX[c]]}; in_data[15:8] ignored.
REQ-017 Any non-alphanumeric byte or no table match SHALL give out_err=1, out_data=0, still one output beat.
REQ-018 Tokens queued during a key rewrite SHALL stall and be processed with the new key once READY; an already registered output is unaffected.
REQ-019 fifo_count SHALL reflect entries after each edge; simultaneous push and pop leaves it unchanged.

Reset
REQ-020 rst SHALL give: key state NO_KEY, all key bytes 8'h00, FIFO empty, fifo_count=0, out_valid=0, out_data=0, out_err=0, key_ready=0, error_flag_key=0.
REQ-021 rst asserted mid-CHECK or with tokens pending SHALL discard all of them; in_ready=1 the first cycle after release.

Structure
REQ-022 Package sub_table_pkg SHALL hold ROWS=6, COLS=6, KEY_LEN, ROW_IDX='{0,11,9,3,5,6}, COL_IDX='{10,8,1,2,4,7}, the key state enum and the alphabet constant.
REQ-023 The FIFO SHALL be the single sub-module sub_table_fifo (synchronous, registered, with count); table lookup stays in the top level.

Verification
REQ-024 Key "ABCDEFGHIJKL" plus commit -> key_ready=1 exactly 12 cycles after CHECK entry; decrypt "AK" upper -> 16'h0041; decrypt "GH" -> 16'h0039.
REQ-025 Same key, encrypt 'z' -> out_data="FI"; encrypt '#' -> out_err=1, out_data=0.
REQ-026 Key "ABCDEFGHIJKA" plus commit -> error_flag_key=1, key_ready=0 after 12 cycles; one key_byte_val -> error_flag_key=0 next cycle.
REQ-027 out_ready=0, push tokens until in_ready=0 -> FIFO_DEPTH+1 tokens accepted, fifo_count=FIFO_DEPTH; release -> outputs in order with no loss or duplication.
REQ-028 Key rewrite with 2 tokens queued -> no output until recommit completes, then results use the new key; rst mid-CHECK -> all outputs at reset values.
